// File: rtl/spm_dp_bank_pkg.sv
// Shared encodings for the dual-port scratchpad bank.
// Direction, strobe and FSM state values used across the SPM slice.
package spm_dp_bank_pkg;

    localparam logic READ        = 1'b1;
    localparam logic WRITE       = 1'b0;
    localparam logic ENABLE_     = 1'b0;
    localparam logic DISABLE_    = 1'b1;
    localparam logic MEM_ENABLE  = 1'b1;
    localparam logic MEM_DISABLE = 1'b0;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_DEPTH  = 4096;

    typedef enum logic {
        SPM_CLEAR = 1'b0,
        SPM_READY = 1'b1
    } spm_state_e;

endpackage

// File: rtl/spm_dp_bank_ram.sv
// True dual-port byte-enabled array with registered read outputs.
// The array itself carries no reset; both ports share one process.
module spm_dp_bank_ram #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NBE    = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              a_rd,
    input  logic [NBE-1:0]    a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_rd,
    input  logic [NBE-1:0]    b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads sample the pre-write word; the top level patches in new lanes.
    always_ff @(posedge clk) begin
        if (a_rd) a_q <= mem[a_addr];
        if (b_rd) b_q <= mem[b_addr];
        for (int i = 0; i < NBE; i++) begin
            if (a_we[i])
                mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
        end
        for (int i = 0; i < NBE; i++) begin
            if (b_we[i])
                mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/spm_dp_bank.sv
// Dual-port scratchpad: A serves instruction fetch, B serves data access.
// Adds a post-reset clear engine, collision merge, write-first bypass and a collision counter.
module spm_dp_bank
    import spm_dp_bank_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 16,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int NBE            = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_as_,
    input  logic              a_rw,
    input  logic [NBE-1:0]    a_be,
    input  logic [DATA_W-1:0] a_wr_data,
    output logic [DATA_W-1:0] a_rd_data,
    output logic              a_rdy_,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_as_,
    input  logic              b_rw,
    input  logic [NBE-1:0]    b_be,
    input  logic [DATA_W-1:0] b_wr_data,
    output logic [DATA_W-1:0] b_rd_data,
    output logic              b_rdy_,
    output logic              clr_busy,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam spm_state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? SPM_CLEAR : SPM_READY;

    spm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              clr_we;
    logic              ready;

    logic a_act, a_wr, a_rd;
    logic b_act, b_wr, b_rd;
    logic same, both_wr, coll;

    logic [NBE-1:0]    a_we_m, b_we_m;
    logic [ADDR_W-1:0] b_addr_m;
    logic [DATA_W-1:0] b_wd_m;
    logic [DATA_W-1:0] a_q, b_q;

    logic [NBE-1:0]    a_bm_d, b_bm_d, a_bm_q, b_bm_q;
    logic [DATA_W-1:0] a_bd_q, b_bd_q;
    logic [DATA_W-1:0] a_bits, b_bits;
    logic [DATA_W-1:0] a_hold_q, b_hold_q;
    logic              a_vld_q, b_vld_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) ptr_q <= ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_we  = MEM_DISABLE;
        unique case (state_q)
            SPM_CLEAR: begin
                clr_we = MEM_ENABLE;
                if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = SPM_READY;
            end
            SPM_READY: state_d = SPM_READY;
            default:   state_d = SPM_READY;
        endcase
    end

    assign ready    = (state_q == SPM_READY);
    assign clr_busy = (state_q == SPM_CLEAR);
    assign a_rdy_   = ready ? ENABLE_ : DISABLE_;
    assign b_rdy_   = ready ? ENABLE_ : DISABLE_;

    assign a_act   = ready && (a_as_ == ENABLE_);
    assign b_act   = ready && (b_as_ == ENABLE_);
    assign a_wr    = a_act && (a_rw == WRITE);
    assign b_wr    = b_act && (b_rw == WRITE);
    assign a_rd    = a_act && (a_rw == READ);
    assign b_rd    = b_act && (b_rw == READ);
    assign same    = (a_addr == b_addr);
    assign both_wr = a_wr && b_wr && same;
    assign coll    = a_act && b_act && same && (a_wr || b_wr);

    // A same-address double write is folded into one port B write.
    always_comb begin
        a_we_m   = (a_wr && !both_wr) ? a_be : '0;
        b_we_m   = '0;
        b_addr_m = b_addr;
        b_wd_m   = '0;
        if (clr_we) begin
            b_we_m   = '1;
            b_addr_m = ptr_q;
        end else if (b_wr) begin
            b_we_m = both_wr ? (a_be | b_be) : b_be;
            for (int i = 0; i < NBE; i++)
                b_wd_m[i*BYTE_W +: BYTE_W] = b_be[i] ?
                    b_wr_data[i*BYTE_W +: BYTE_W] :
                    a_wr_data[i*BYTE_W +: BYTE_W];
        end
    end

    spm_dp_bank_ram #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NBE    (NBE)
    ) u_ram (
        .clk     (clk),
        .a_rd    (a_rd),
        .a_we    (a_we_m),
        .a_addr  (a_addr),
        .a_wdata (a_wr_data),
        .a_q     (a_q),
        .b_rd    (b_rd),
        .b_we    (b_we_m),
        .b_addr  (b_addr_m),
        .b_wdata (b_wd_m),
        .b_q     (b_q)
    );

    assign a_bm_d = (a_rd && b_wr && same) ? b_be : '0;
    assign b_bm_d = (b_rd && a_wr && same) ? a_be : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            a_bm_q   <= '0;
            b_bm_q   <= '0;
            a_bd_q   <= '0;
            b_bd_q   <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
            cnt_q    <= '0;
        end else begin
            a_vld_q  <= a_rd;
            b_vld_q  <= b_rd;
            a_bm_q   <= a_bm_d;
            b_bm_q   <= b_bm_d;
            a_bd_q   <= b_wr_data;
            b_bd_q   <= a_wr_data;
            a_hold_q <= a_rd_data;
            b_hold_q <= b_rd_data;
            if (coll && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        a_bits = '0;
        b_bits = '0;
        for (int i = 0; i < NBE; i++) begin
            a_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{a_bm_q[i]}};
            b_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{b_bm_q[i]}};
        end
    end

    // Read result is the array word with the other port's new lanes patched in.
    assign a_rd_data = a_vld_q ? ((a_q & ~a_bits) | (a_bd_q & a_bits)) : a_hold_q;
    assign b_rd_data = b_vld_q ? ((b_q & ~b_bits) | (b_bd_q & b_bits)) : b_hold_q;
    assign coll_cnt  = cnt_q;

endmodule

// File: tb/tb_spm_dp_bank.sv
// Randomized and directed bench for spm_dp_bank against a word-array reference model.
// Small geometry (DEPTH=16, CNT_W=2) keeps clear short and exercises saturation.
module tb_spm_dp_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_as_, b_as_, a_rw, b_rw;
    logic [NB-1:0] a_be, b_be;
    logic [DW-1:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
    logic          a_rdy_, b_rdy_, clr_busy;
    logic [CW-1:0] coll_cnt;

    always #5 clk = ~clk;

    spm_dp_bank #(
        .DATA_W(DW), .BYTE_W(8), .DEPTH(DEPTH),
        .CLEAR_ON_RESET(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_as_(a_as_), .a_rw(a_rw), .a_be(a_be),
        .a_wr_data(a_wr_data), .a_rd_data(a_rd_data), .a_rdy_(a_rdy_),
        .b_addr(b_addr), .b_as_(b_as_), .b_rw(b_rw), .b_be(b_be),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .b_rdy_(b_rdy_),
        .clr_busy(clr_busy), .coll_cnt(coll_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [DEPTH];
    int          clr_left;
    logic [31:0] exp_a, exp_b;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_all();
        chk("a_rd_data", 64'(a_rd_data), 64'(exp_a));
        chk("b_rd_data", 64'(b_rd_data), 64'(exp_b));
        chk("a_rdy_", 64'(a_rdy_), 64'(clr_left != 0));
        chk("b_rdy_", 64'(b_rdy_), 64'(clr_left != 0));
        chk("clr_busy", 64'(clr_busy), 64'(clr_left != 0));
        chk("coll_cnt", 64'(coll_cnt), 64'(exp_cnt));
    endtask

    // Reference: apply writes (A then B, so B wins lanes), then reads see the new array.
    task automatic model();
        logic aw, bw, aa, ba;
        if (clr_left > 0) begin
            mdl[DEPTH - clr_left] = 32'h0;
            clr_left--;
            return;
        end
        aa = !a_as_;
        ba = !b_as_;
        aw = aa && !a_rw;
        bw = ba && !b_rw;
        for (int i = 0; i < NB; i++)
            if (aw && a_be[i]) mdl[a_addr][i*8 +: 8] = a_wr_data[i*8 +: 8];
        for (int i = 0; i < NB; i++)
            if (bw && b_be[i]) mdl[b_addr][i*8 +: 8] = b_wr_data[i*8 +: 8];
        if (aa && a_rw) exp_a = mdl[a_addr];
        if (ba && b_rw) exp_b = mdl[b_addr];
        if (aa && ba && a_addr == b_addr && (aw || bw) && exp_cnt < CMAX)
            exp_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check_all();
    endtask

    task automatic idle();
        a_as_ = 1'b1;
        b_as_ = 1'b1;
    endtask

    task automatic a_set(input logic rw, input int ad, input logic [3:0] be, input logic [31:0] d);
        a_as_ = 1'b0; a_rw = rw; a_addr = AW'(ad); a_be = be; a_wr_data = d;
    endtask

    task automatic b_set(input logic rw, input int ad, input logic [3:0] be, input logic [31:0] d);
        b_as_ = 1'b0; b_rw = rw; b_addr = AW'(ad); b_be = be; b_wr_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        clr_left = DEPTH;
        exp_a = 32'h0;
        exp_b = 32'h0;
        exp_cnt = 0;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        a_rw = 1'b1; b_rw = 1'b1; a_addr = '0; b_addr = '0;
        a_be = '0; b_be = '0; a_wr_data = '0; b_wr_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        repeat (DEPTH) tick();
        chk("t1_busy_end", 64'(clr_busy), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a_set(1'b1, i, 4'h0, 32'h0);
            b_set(1'b1, DEPTH - 1 - i, 4'h0, 32'h0);
            tick();
            chk("t1_zero_a", 64'(a_rd_data), 64'd0);
            chk("t1_zero_b", 64'(b_rd_data), 64'd0);
        end
        idle();

        b_set(1'b0, 5, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        a_set(1'b1, 5, 4'h0, 32'h0);
        tick();
        chk("t2_a_read", 64'(a_rd_data), 64'hDEADBEEF);
        idle();
        b_set(1'b0, 5, 4'h1, 32'h000000AA);
        tick();
        b_set(1'b1, 5, 4'h0, 32'h0);
        tick();
        chk("t2_b_merge", 64'(b_rd_data), 64'hDEADBEAA);
        idle();

        a_set(1'b0, 7, 4'hF, 32'h11111111);
        b_set(1'b0, 7, 4'h3, 32'h22222222);
        tick();
        idle();
        a_set(1'b1, 7, 4'h0, 32'h0);
        tick();
        chk("t3_collide", 64'(a_rd_data), 64'h11112222);
        chk("t3_cnt", 64'(coll_cnt), 64'd1);

        a_set(1'b1, 3, 4'h0, 32'h0);
        b_set(1'b0, 3, 4'hC, 32'h12345678);
        tick();
        chk("t4_bypass", 64'(a_rd_data), 64'h12340000);
        chk("t4_cnt", 64'(coll_cnt), 64'd2);
        idle();

        do_reset();
        a_set(1'b0, 2, 4'hF, 32'hFFFFFFFF);
        repeat (8) tick();
        chk("t5_held", 64'(a_rd_data), 64'd0);
        do_reset();
        chk("t6_cnt_rst", 64'(coll_cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t6_busy", 64'(clr_busy), 64'd1);
            tick();
        end
        chk("t6_ready", 64'(a_rdy_), 64'd0);
        a_set(1'b1, 2, 4'h0, 32'h0);
        tick();
        chk("t5_ignored", 64'(a_rd_data), 64'd0);

        for (int i = 0; i < 5; i++) begin
            a_set(1'b0, 1, 4'hF, 32'(i));
            b_set(1'b0, 1, 4'h5, 32'(i * 3));
            tick();
        end
        chk("t6_sat", 64'(coll_cnt), 64'd3);
        idle();

        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin
                do_reset();
            end
            a_as_ = ($urandom_range(0, 3) == 0);
            b_as_ = ($urandom_range(0, 3) == 0);
            a_rw = 1'($urandom);
            b_rw = 1'($urandom);
            a_addr = AW'($urandom_range(0, 3));
            b_addr = AW'($urandom_range(0, 3));
            a_be = NB'($urandom);
            b_be = NB'($urandom);
            a_wr_data = $urandom;
            b_wr_data = $urandom;
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
